accel_rr_scheduler: RTL and testbench
=====================================

Name: accel_rr_scheduler

Overview:
- Round-robin scheduler that shares one exponent accelerator between N_REQ requesters.
- Latches the winning requester's operands and pulses the accelerator start.
- Routes every accelerator write beat and the final done back to the granted requester.
- Sits between requester front-ends and the accelerator's start/done/write interface; contains no arithmetic of its own.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- UI_W, 2, integer-part operand width
- VI_W, 5, fractional-part operand width
- DATA_W, 21, accelerator write-data width
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester job request, level, held until its rsp_done
- ui_bus  in  N_REQ*UI_W  packed ui operands; requester k uses slice k
- vi_bus  in  N_REQ*VI_W  packed vi operands; requester k uses slice k
- gnt  out  N_REQ  one-hot grant, high for the whole job
- rsp_valid  out  N_REQ  one-hot; pulses with each forwarded write beat
- rsp_data  out  DATA_W  shared response data, meaningful when any rsp_valid is high
- rsp_done  out  N_REQ  one-hot, one-cycle pulse at job end
- err  out  1  one-cycle pulse on watchdog abort
- acc_start  out  1  one-cycle start pulse to the accelerator
- acc_ui  out  UI_W  latched operand
- acc_vi  out  VI_W  latched operand
- acc_wrReq  in  1  accelerator write strobe
- acc_wrData  in  DATA_W  accelerator write data
- acc_done  in  1  accelerator completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0. gnt, rsp_valid, rsp_done, err, acc_start=0; acc_ui, acc_vi, rsp_data=0.
- All outputs are registered.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr, scanning upward modulo N_REQ.
  - Register gnt, acc_ui and acc_vi from that requester's slice; go to LAUNCH.
- LAUNCH (1 cycle): acc_start=1; go to BUSY.
  - Latency: req sampled in IDLE at cycle t gives gnt at t+1 and acc_start at t+1.
- BUSY:
  - Each cycle acc_wrReq=1: next cycle rsp_data=acc_wrData and rsp_valid=gnt.
  - On acc_done: next cycle rsp_done=gnt; go to RELEASE.
  - If acc_wrReq and acc_done arrive together, both the beat and the done are forwarded in the same output cycle.
- RELEASE (1 cycle):
  - gnt=0.
  - rr_ptr = (granted index + 1) mod N_REQ.
  - Go to IDLE.
  - Requesters must drop req by the cycle after rsp_done; a req still high in IDLE is treated as a new job.
- Accelerator inputs outside BUSY:
  - acc_wrReq and acc_done are ignored in IDLE, LAUNCH and RELEASE.
  - Stray beats are dropped silently.
- Operands are sampled only at grant; ui_bus/vi_bus changes during a job have no effect.
- Dropping req mid-job does not abort it; the job completes and responses are still sent to that index.
- Fairness: with all req high, grants cycle 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 jobs.
- Reset mid-job: all outputs return to reset values immediately. The accelerator must be reset by the same rst.
- Without the optional feature, err is tied 0.

Optional Feature:
- Macro: ACCEL_TIMEOUT_EN.
- When defined:
  - A cycle counter clears in LAUNCH and increments in BUSY.
  - If it reaches TIMEOUT_CYC with no acc_done, the next cycle asserts rsp_done=gnt and err=1 (one cycle), then goes to RELEASE.
  - The accelerator is expected to be re-reset externally after an abort.
- When undefined:
  - No counter is built; BUSY waits indefinitely.
  - err=0 constantly.

Decomposition:
- Shared package accel_sched_pkg holds:
  - state typedef {IDLE, LAUNCH, BUSY, RELEASE}
  - default widths UI_W=2, VI_W=5, DATA_W=21
  - the one-hot-to-index function
- One sub-module, rr_arbiter: combinational round-robin pick from req and rr_ptr, producing one-hot plus index.
- FSM, operand latch and response routing stay in accel_rr_scheduler.

Test Plan:
- Single job: req=0001, ui_bus[1:0]=2'b01, vi_bus[4:0]=5'b10000.
  - gnt=0001 and acc_start one cycle after req.
  - acc_ui=1, acc_vi=16.
  - Model emits 3 beats 0x00001, 0x00002, 0x00003, then done: rsp_valid[0] pulses 3 times with matching rsp_data, then rsp_done=0001.
- Contention: req=1111 held, each job 2 beats.
  - Grant order 0,1,2,3,0.
  - No rsp_valid ever appears on a non-granted index.
- Simultaneous last beat and done: acc_wrReq=1 with acc_wrData=0x1FFFF and acc_done=1 in the same cycle.
  - Next cycle rsp_valid, rsp_data=0x1FFFF and rsp_done all asserted for the granted index.
- Operand change and req drop mid-job: after grant to requester 2, change its vi slice to 0 and drop req[2].
  - acc_vi keeps its original value.
  - The job completes with rsp_done[2].
- Reset mid-BUSY: pull rst low asynchronously between clock edges.
  - gnt, acc_start, rsp_* and err go to 0 without waiting for a clock edge.
  - After release, the first grant goes to index 0.
- Timeout (ACCEL_TIMEOUT_EN, TIMEOUT_CYC=20): model never asserts done.
  - rsp_done and err pulse 21 cycles after acc_start.
  - The next req is granted normally.

Source files
------------

// File: rtl/accel_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : accel_sched_pkg
// Brief  : Shared types, default widths and helpers for the round-robin
//          exponent-accelerator scheduler.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   state_t        scheduler FSM state encoding (IDLE, LAUNCH, BUSY, RELEASE)
//   c_max_req      largest supported requester count
//   c_idx_w        width of a requester index / round-robin pointer
//   c_ui_w/c_vi_w  default operand widths
//   c_data_w       default accelerator write-data width
//   onehot_to_idx  one-hot vector to binary index
// ============================================================================
package accel_sched_pkg;

    localparam int c_max_req = 8;
    localparam int c_idx_w   = 3;
    localparam int c_ui_w    = 2;
    localparam int c_vi_w    = 5;
    localparam int c_data_w  = 21;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // OR-based encoder: exact for a one-hot input, '0 for an all-zero input.
    function automatic logic [c_idx_w-1:0] onehot_to_idx(input logic [c_max_req-1:0] oh);
        logic [c_idx_w-1:0] idx;
        idx = '0;
        for (int k = 0; k < c_max_req; k++) begin
            if (oh[k]) begin
                idx = idx | c_idx_w'(k);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick. Selects the first asserted request
//          at or above rr_ptr, wrapping to the lowest asserted request.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   req      in   N_REQ    request vector
//   rr_ptr   in   c_idx_w  highest-priority index for this pick
//   gnt_oh   out  N_REQ    one-hot winner (all zero when req is zero)
//   gnt_idx  out  c_idx_w  binary index of the winner
// ============================================================================
module rr_arbiter
    import accel_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [c_idx_w-1:0] rr_ptr,
    output logic [N_REQ-1:0]   gnt_oh,
    output logic [c_idx_w-1:0] gnt_idx
);

    logic [N_REQ-1:0] w_hi_oh;
    logic [N_REQ-1:0] w_lo_oh;
    logic             w_hi_found;

    // Scanning downward means the last hit is the lowest index: w_hi_oh is the
    // lowest request at or above the pointer, w_lo_oh the lowest overall
    // (the wrap-around candidate).
    always_comb begin
        w_hi_oh    = '0;
        w_lo_oh    = '0;
        w_hi_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_lo_oh    = '0;
                w_lo_oh[k] = 1'b1;
                if (c_idx_w'(k) >= rr_ptr) begin
                    w_hi_oh    = '0;
                    w_hi_oh[k] = 1'b1;
                    w_hi_found = 1'b1;
                end
            end
        end
        gnt_oh = w_hi_found ? w_hi_oh : w_lo_oh;
    end

    assign gnt_idx = onehot_to_idx(c_max_req'(gnt_oh));

endmodule
`default_nettype wire

// File: rtl/accel_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : accel_rr_scheduler
// Brief  : Shares one exponent accelerator between N_REQ requesters. Grants
//          round-robin, latches the winner's operands, pulses acc_start and
//          routes write beats and completion back to the granted requester.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ACCEL_TIMEOUT_EN
//   defined   -> BUSY watchdog of TIMEOUT_CYC cycles; abort pulses rsp_done+err
//   undefined -> no counter, BUSY waits for acc_done, err tied 0
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1             clock, rising edge
//   rst         in   1             asynchronous active-low reset
//   req         in   N_REQ         level job request per requester
//   ui_bus      in   N_REQ*UI_W    packed ui operands (slice k = requester k)
//   vi_bus      in   N_REQ*VI_W    packed vi operands (slice k = requester k)
//   gnt         out  N_REQ         one-hot grant for the job duration
//   rsp_valid   out  N_REQ         one-hot pulse per forwarded write beat
//   rsp_data    out  DATA_W        forwarded write data
//   rsp_done    out  N_REQ         one-hot job-end pulse
//   err         out  1             watchdog abort pulse
//   acc_start   out  1             accelerator start pulse
//   acc_ui      out  UI_W          latched ui operand
//   acc_vi      out  VI_W          latched vi operand
//   acc_wrReq   in   1             accelerator write strobe
//   acc_wrData  in   DATA_W        accelerator write data
//   acc_done    in   1             accelerator completion pulse
// ============================================================================
module accel_rr_scheduler
    import accel_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int UI_W        = c_ui_w,
    parameter int VI_W        = c_vi_w,
    parameter int DATA_W      = c_data_w,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*UI_W-1:0] ui_bus,
    input  logic [N_REQ*VI_W-1:0] vi_bus,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [N_REQ-1:0]      rsp_done,
    output logic                  err,
    output logic                  acc_start,
    output logic [UI_W-1:0]       acc_ui,
    output logic [VI_W-1:0]       acc_vi,
    input  logic                  acc_wrReq,
    input  logic [DATA_W-1:0]     acc_wrData,
    input  logic                  acc_done
);

    state_t              state_q, state_d;
    logic [c_idx_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [c_idx_w-1:0]  idx_q, idx_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0]    rsp_done_q, rsp_done_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                acc_start_q, acc_start_d;
    logic [UI_W-1:0]     acc_ui_q, acc_ui_d;
    logic [VI_W-1:0]     acc_vi_q, acc_vi_d;

    logic [N_REQ-1:0]    w_arb_oh;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic [UI_W-1:0]     w_ui_sel;
    logic [VI_W-1:0]     w_vi_sel;
    logic                w_finish;

`ifdef ACCEL_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (w_arb_oh),
        .gnt_idx (w_arb_idx)
    );

    // Operand slice of the arbitration winner (one-hot mux).
    always_comb begin
        w_ui_sel = '0;
        w_vi_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_arb_oh[k]) begin
                w_ui_sel = ui_bus[k*UI_W +: UI_W];
                w_vi_sel = vi_bus[k*VI_W +: VI_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_done_d  = '0;
        rsp_data_d  = rsp_data_q;
        acc_start_d = 1'b0;
        acc_ui_d    = acc_ui_q;
        acc_vi_d    = acc_vi_q;
        w_finish    = 1'b0;
`ifdef ACCEL_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d       = w_arb_oh;
                    idx_d       = w_arb_idx;
                    acc_ui_d    = w_ui_sel;
                    acc_vi_d    = w_vi_sel;
                    // Registered so the pulse coincides with the LAUNCH cycle.
                    acc_start_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
`ifdef ACCEL_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = BUSY;
            end
            BUSY: begin
                if (acc_wrReq) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = acc_wrData;
                end
                if (acc_done) begin
                    w_finish = 1'b1;
                end
`ifdef ACCEL_TIMEOUT_EN
                // cnt_q == TIMEOUT_CYC-1 is the cycle the count reaches the
                // limit; the abort is then registered for the next cycle.
                else if (cnt_q == c_cnt_w'(TIMEOUT_CYC - 1)) begin
                    w_finish = 1'b1;
                    err_d    = 1'b1;
                end
                cnt_d = cnt_q + c_cnt_w'(1);
`endif
                if (w_finish) begin
                    rsp_done_d = gnt_q;
                    gnt_d      = '0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                rr_ptr_d = (idx_q == c_idx_w'(N_REQ - 1)) ? '0 : idx_q + c_idx_w'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_done_q  <= '0;
            rsp_data_q  <= '0;
            acc_start_q <= 1'b0;
            acc_ui_q    <= '0;
            acc_vi_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_done_q  <= rsp_done_d;
            rsp_data_q  <= rsp_data_d;
            acc_start_q <= acc_start_d;
            acc_ui_q    <= acc_ui_d;
            acc_vi_q    <= acc_vi_d;
        end
    end

`ifdef ACCEL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_data  = rsp_data_q;
    assign acc_start = acc_start_q;
    assign acc_ui    = acc_ui_q;
    assign acc_vi    = acc_vi_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_accel_rr_scheduler
// Brief  : Self-checking bench for accel_rr_scheduler. Directed scenarios plus
//          randomized jobs, checked against a round-robin reference model that
//          scans requesters from a pointer with modulo arithmetic.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ACCEL_TIMEOUT_EN (adds the watchdog scenario with
// TIMEOUT_CYC = 20).
// ============================================================================
module tb_accel_rr_scheduler;

    localparam int N      = 4;
    localparam int UI_W   = 2;
    localparam int VI_W   = 5;
    localparam int DATA_W = 21;
`ifdef ACCEL_TIMEOUT_EN
    localparam int TMO    = 20;
`else
    localparam int TMO    = 1023;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*UI_W-1:0]   ui_bus;
    logic [N*VI_W-1:0]   vi_bus;
    logic [N-1:0]        gnt;
    logic [N-1:0]        rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic [N-1:0]        rsp_done;
    logic                err;
    logic                acc_start;
    logic [UI_W-1:0]     acc_ui;
    logic [VI_W-1:0]     acc_vi;
    logic                acc_wrReq;
    logic [DATA_W-1:0]   acc_wrData;
    logic                acc_done;

    int                  n_checks = 0;
    int                  n_err    = 0;
    int                  ptr      = 0;
    logic [UI_W-1:0]     exp_ui;
    logic [VI_W-1:0]     exp_vi;
    logic [DATA_W-1:0]   beat_data [8];

    accel_rr_scheduler #(
        .N_REQ       (N),
        .UI_W        (UI_W),
        .VI_W        (VI_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ui_bus     (ui_bus),
        .vi_bus     (vi_bus),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_done   (rsp_done),
        .err        (err),
        .acc_start  (acc_start),
        .acc_ui     (acc_ui),
        .acc_vi     (acc_vi),
        .acc_wrReq  (acc_wrReq),
        .acc_wrData (acc_wrData),
        .acc_done   (acc_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] e_gnt, input logic e_start,
                           input logic [N-1:0] e_valid, input logic [DATA_W-1:0] e_data,
                           input logic [N-1:0] e_done, input logic e_err);
        chk(tag, "gnt",       64'(gnt),       64'(e_gnt));
        chk(tag, "acc_start", 64'(acc_start), 64'(e_start));
        chk(tag, "rsp_valid", 64'(rsp_valid), 64'(e_valid));
        if (e_valid != '0) chk(tag, "rsp_data", 64'(rsp_data), 64'(e_data));
        chk(tag, "rsp_done",  64'(rsp_done),  64'(e_done));
        chk(tag, "err",       64'(err),       64'(e_err));
        chk(tag, "acc_ui",    64'(acc_ui),    64'(exp_ui));
        chk(tag, "acc_vi",    64'(acc_vi),    64'(exp_vi));
    endtask

    // Reference arbitration: first asserted request at or after ptr, mod N.
    function automatic int pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // One complete job: grant, optional stray accelerator activity in LAUNCH,
    // nbeats forwarded beats (with random idle gaps), then done (optionally
    // merged with the last beat), release and return to idle.
    task automatic run_job(input logic [N-1:0] mask, input int nbeats, input bit merge, input bit stray);
        int           w;
        logic [N-1:0] oh;
        w  = pick(mask);
        oh = '0;
        oh[w] = 1'b1;
        exp_ui = ui_bus[w*UI_W +: UI_W];
        exp_vi = vi_bus[w*VI_W +: VI_W];
        req = mask;
        step();
        chk_all("grant", oh, 1'b1, '0, '0, '0, 1'b0);
        // Operands and requests change after grant; none of it may matter.
        ui_bus = ~ui_bus;
        vi_bus = ~vi_bus;
        req    = N'($urandom);
        if (stray) begin
            acc_wrReq  = 1'b1;
            acc_wrData = DATA_W'($urandom);
            acc_done   = 1'b1;
        end
        step();
        chk_all("busy_entry", oh, 1'b0, '0, '0, '0, 1'b0);
        acc_wrReq = 1'b0;
        acc_done  = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk_all("gap", oh, 1'b0, '0, '0, '0, 1'b0);
            end
            acc_wrReq  = 1'b1;
            acc_wrData = beat_data[b];
            if (merge && b == nbeats - 1) acc_done = 1'b1;
            step();
            acc_wrReq = 1'b0;
            if (merge && b == nbeats - 1)
                chk_all("beat_done", '0, 1'b0, oh, beat_data[b], oh, 1'b0);
            else
                chk_all("beat", oh, 1'b0, oh, beat_data[b], '0, 1'b0);
        end
        if (!merge) begin
            acc_done = 1'b1;
            step();
            chk_all("done", '0, 1'b0, '0, '0, oh, 1'b0);
        end
        acc_done = 1'b0;
        req      = '0;
        step();
        chk_all("idle", '0, 1'b0, '0, '0, '0, 1'b0);
        ptr = (w + 1) % N;
    endtask

    task automatic rand_beats();
        for (int i = 0; i < 8; i++) beat_data[i] = DATA_W'($urandom);
    endtask

    initial begin
        int           w;
        int           nb;
        logic [N-1:0] m;
        logic [N-1:0] oh;

        rst        = 1'b0;
        req        = '0;
        ui_bus     = '0;
        vi_bus     = '0;
        acc_wrReq  = 1'b0;
        acc_wrData = '0;
        acc_done   = 1'b0;
        exp_ui     = '0;
        exp_vi     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", '0, 1'b0, '0, '0, '0, 1'b0);
        chk("reset", "rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b1;
        step();

        // Single job on requester 0 with three beats.
        ui_bus       = {6'b000000, 2'b01};
        vi_bus       = {15'd0, 5'b10000};
        beat_data[0] = 21'h00001;
        beat_data[1] = 21'h00002;
        beat_data[2] = 21'h00003;
        run_job(4'b0001, 3, 1'b0, 1'b0);

        // Contention: all requesting, two beats per job, stray activity in LAUNCH.
        for (int j = 0; j < 5; j++) begin
            ui_bus = (N*UI_W)'($urandom);
            vi_bus = (N*VI_W)'($urandom);
            rand_beats();
            run_job(4'b1111, 2, 1'b0, 1'b1);
        end

        // Last beat and done in the same cycle.
        beat_data[0] = 21'h1FFFF;
        run_job(4'b1011, 1, 1'b1, 1'b0);

        // Operand change and request drop after grant to requester 2.
        ui_bus = (N*UI_W)'($urandom);
        vi_bus = (N*VI_W)'($urandom);
        rand_beats();
        run_job(4'b0100, 2, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            m      = N'($urandom_range(1, (1 << N) - 1));
            nb     = $urandom_range(0, 4);
            ui_bus = (N*UI_W)'($urandom);
            vi_bus = (N*VI_W)'($urandom);
            rand_beats();
            run_job(m, nb, (nb > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of BUSY.
        m      = N'($urandom_range(1, (1 << N) - 1));
        w      = pick(m);
        oh     = '0;
        oh[w]  = 1'b1;
        ui_bus = (N*UI_W)'($urandom);
        vi_bus = (N*VI_W)'($urandom);
        exp_ui = ui_bus[w*UI_W +: UI_W];
        exp_vi = vi_bus[w*VI_W +: VI_W];
        req    = m;
        step();
        chk_all("rst_grant", oh, 1'b1, '0, '0, '0, 1'b0);
        step();
        acc_wrReq  = 1'b1;
        acc_wrData = 21'h0ABCD;
        step();
        acc_wrReq  = 1'b0;
        chk_all("rst_beat", oh, 1'b0, oh, 21'h0ABCD, '0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        exp_ui = '0;
        exp_vi = '0;
        chk_all("rst_async", '0, 1'b0, '0, '0, '0, 1'b0);
        chk("rst_async", "rsp_data", 64'(rsp_data), 64'd0);
        step();
        chk_all("rst_held", '0, 1'b0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        req = '0;
        ptr = 0;
        rand_beats();
        run_job(4'b1111, 1, 1'b0, 1'b0);

`ifdef ACCEL_TIMEOUT_EN
        // Watchdog abort: the accelerator never signals done.
        w      = pick(4'b1000);
        oh     = '0;
        oh[w]  = 1'b1;
        exp_ui = ui_bus[w*UI_W +: UI_W];
        exp_vi = vi_bus[w*VI_W +: VI_W];
        req    = 4'b1000;
        step();
        chk_all("tmo_grant", oh, 1'b1, '0, '0, '0, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k < 21) chk_all("tmo_wait", oh, 1'b0, '0, '0, '0, 1'b0);
            else        chk_all("tmo_abort", '0, 1'b0, '0, '0, oh, 1'b1);
        end
        req = '0;
        step();
        chk_all("tmo_idle", '0, 1'b0, '0, '0, '0, 1'b0);
        ptr = (w + 1) % N;
        rand_beats();
        run_job(4'b0011, 2, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
